// File: rtl/freq_div_prog.sv
// freq_div_prog: programmable frequency divider and scan-index generator.
// Divides clksys by a run-time-loadable divisor D >= 2 and produces a
// one-cycle tick, a near-50%-duty divided clock and a wrapping scan index.
// Optional feature macro: FREQDIV_TICK_CNT_EN adds a saturating 16-bit
// tick counter output (tick_cnt), cleared by reset and by div_load.
module freq_div_prog #(
    parameter int CNT_WIDTH   = 27,
    parameter int DEFAULT_DIV = 262144,
    parameter int SCAN_NUM    = 4,
    parameter int SCAN_WIDTH  = 2
) (
    input  logic                  clksys,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  div_load,
    input  logic [CNT_WIDTH-1:0]  div_value,
    output logic                  tick,
    output logic                  clk_div,
`ifdef FREQDIV_TICK_CNT_EN
    output logic [15:0]           tick_cnt,
`endif
    output logic [SCAN_WIDTH-1:0] scan_idx
);

    localparam logic [CNT_WIDTH-1:0]  DEF_D     = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0]  MIN_D     = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [SCAN_WIDTH-1:0] LAST_SCAN = SCAN_WIDTH'(SCAN_NUM - 1);
    localparam logic [SCAN_WIDTH-1:0] SCAN_ONE  = SCAN_WIDTH'(1);

    logic [CNT_WIDTH-1:0] div_r;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 term;

    // Divisors below 2 cannot produce a distinct tick, so they clamp to 2.
    function automatic logic [CNT_WIDTH-1:0] clamp_div(input logic [CNT_WIDTH-1:0] v);
        return (v < MIN_D) ? MIN_D : v;
    endfunction

    // Threshold ceil(D/2): clk_div is low for this many counts per period.
    function automatic logic [CNT_WIDTH-1:0] half_ceil(input logic [CNT_WIDTH-1:0] d);
        return d - (d >> 1);
    endfunction

    // Explicit wrap so non-power-of-two SCAN_NUM values work.
    function automatic logic [SCAN_WIDTH-1:0] next_scan(input logic [SCAN_WIDTH-1:0] s);
        return (s == LAST_SCAN) ? '0 : s + SCAN_ONE;
    endfunction

    // Terminal-count detect and next counter value for an enabled cycle.
    always_comb begin
        term    = (cnt == div_r - CNT_ONE);
        cnt_nxt = term ? '0 : cnt + CNT_ONE;
    end

    // Counter, divisor and registered outputs; priority rst > div_load > en.
    always_ff @(posedge clksys) begin
        if (rst) begin
            div_r    <= DEF_D;
            cnt      <= '0;
            tick     <= 1'b0;
            clk_div  <= 1'b0;
            scan_idx <= '0;
`ifdef FREQDIV_TICK_CNT_EN
            tick_cnt <= '0;
`endif
        end else if (div_load) begin
            // A load abandons the current period, including a pending tick.
            div_r    <= clamp_div(div_value);
            cnt      <= '0;
            tick     <= 1'b0;
            clk_div  <= 1'b0;
`ifdef FREQDIV_TICK_CNT_EN
            tick_cnt <= '0;
`endif
        end else if (en) begin
            cnt     <= cnt_nxt;
            tick    <= term;
            clk_div <= (cnt_nxt >= half_ceil(div_r));
            if (term) begin
                scan_idx <= next_scan(scan_idx);
`ifdef FREQDIV_TICK_CNT_EN
                if (tick_cnt != 16'hFFFF)
                    tick_cnt <= tick_cnt + 16'd1;
`endif
            end
        end else begin
            // Paused: state holds, but tick is never stretched.
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_div_prog.sv
// Directed testbench for freq_div_prog, built with a small DEFAULT_DIV so
// the default-divisor behaviour is observable within a short run.
module tb_freq_div_prog;

    localparam int CW  = 27;
    localparam int DEF = 12;

    logic          clksys = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          div_load = 1'b0;
    logic [CW-1:0] div_value = '0;
    logic          tick;
    logic          clk_div;
    logic [1:0]    scan_idx;
`ifdef FREQDIV_TICK_CNT_EN
    logic [15:0]   tick_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int exp_scan = 0;

    freq_div_prog #(
        .CNT_WIDTH(CW), .DEFAULT_DIV(DEF), .SCAN_NUM(4), .SCAN_WIDTH(2)
    ) dut (
        .clksys(clksys), .rst(rst), .en(en), .div_load(div_load),
        .div_value(div_value), .tick(tick), .clk_div(clk_div),
`ifdef FREQDIV_TICK_CNT_EN
        .tick_cnt(tick_cnt),
`endif
        .scan_idx(scan_idx)
    );

    always #5 clksys = ~clksys;

    task automatic step();
        @(posedge clksys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check all outputs given the expected counter value after this edge.
    task automatic chk_cycle(input string tag, input int c, input int d, input bit exp_tick);
        if (exp_tick) exp_scan = (exp_scan + 1) % 4;
        chk({tag, ".tick"}, 32'(tick), 32'(exp_tick));
        chk({tag, ".clk_div"}, 32'(clk_div), 32'(c >= d - d / 2));
        chk({tag, ".scan"}, 32'(scan_idx), 32'(exp_scan));
    endtask

    task automatic load(input int v);
        div_load  = 1'b1;
        div_value = CW'(v);
        step();
        div_load  = 1'b0;
        chk("load.tick", 32'(tick), 32'd0);
        chk("load.clk_div", 32'(clk_div), 32'd0);
        chk("load.scan", 32'(scan_idx), 32'(exp_scan));
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst.tick", 32'(tick), 32'd0);
        chk("rst.clk_div", 32'(clk_div), 32'd0);
        chk("rst.scan", 32'(scan_idx), 32'd0);
`ifdef FREQDIV_TICK_CNT_EN
        chk("rst.tick_cnt", 32'(tick_cnt), 32'd0);
`endif

        // Default divisor: first tick after the DEF-th enabled edge
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 1; k <= DEF; k++) begin
            step();
            chk_cycle("def", k % DEF, DEF, k == DEF);
        end
`ifdef FREQDIV_TICK_CNT_EN
        chk("def.tick_cnt", 32'(tick_cnt), 32'd1);
`endif

        // D = 5: pattern 0,0,0,1,1 and tick every 5 cycles
        load(5);
        for (int j = 1; j <= 20; j++) begin
            step();
            chk_cycle("d5", j % 5, 5, (j % 5) == 0);
        end
`ifdef FREQDIV_TICK_CNT_EN
        chk("d5.tick_cnt", 32'(tick_cnt), 32'd4);
`endif

        // div_value 0 and 1 clamp to 2
        load(0);
        for (int j = 1; j <= 6; j++) begin
            step();
            chk_cycle("d0", j % 2, 2, (j % 2) == 0);
        end
        load(1);
        for (int j = 1; j <= 6; j++) begin
            step();
            chk_cycle("d1", j % 2, 2, (j % 2) == 0);
        end

        // D = 6 with a 3-cycle pause at cnt = 4
        load(6);
        for (int j = 1; j <= 6; j++) begin
            step();
            chk_cycle("d6a", j % 6, 6, j == 6);
        end
        for (int j = 1; j <= 4; j++) begin
            step();
            chk_cycle("d6b", j, 6, 1'b0);
        end
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk_cycle("pause", 4, 6, 1'b0);
        end
        en = 1'b1;
        step();
        chk_cycle("d6c", 5, 6, 1'b0);
        step();
        chk_cycle("d6d", 0, 6, 1'b1);

        // D = 4, reload to 8 in the terminal cycle suppresses the tick
        load(4);
        for (int j = 1; j <= 3; j++) begin
            step();
            chk_cycle("d4", j, 4, 1'b0);
        end
        load(8);
        for (int j = 1; j <= 8; j++) begin
            step();
            chk_cycle("d8", j % 8, 8, j == 8);
        end

        // D = 10, reset mid-period restores DEFAULT_DIV
        load(10);
        for (int j = 1; j <= 4; j++) begin
            step();
            chk_cycle("d10", j, 10, 1'b0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_scan = 0;
        chk("rst2.tick", 32'(tick), 32'd0);
        chk("rst2.clk_div", 32'(clk_div), 32'd0);
        chk("rst2.scan", 32'(scan_idx), 32'd0);
`ifdef FREQDIV_TICK_CNT_EN
        chk("rst2.tick_cnt", 32'(tick_cnt), 32'd0);
`endif
        for (int k = 1; k <= DEF; k++) begin
            step();
            chk_cycle("def2", k % DEF, DEF, k == DEF);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/freq_div_prog.md
Name: freq_div_prog

Overview:
Programmable, parametrised frequency divider and scan-index generator. Successor to the fixed power-of-two divider used for the seven-segment display scan.
- Divides clksys by a run-time-loadable integer D (not restricted to powers of two).
- Emits a one-cycle tick, a near-50%-duty divided clock, and a wrapping scan index for multiplexed displays.
- Sits between the system clock and the display, keypad and debounce blocks.

Parameters:
CNT_WIDTH, 27, width of divisor register and period counter.
DEFAULT_DIV, 262144, divisor D loaded at reset. Must satisfy 2 <= DEFAULT_DIV < 2^CNT_WIDTH.
SCAN_NUM, 4, number of scan positions. scan_idx cycles 0..SCAN_NUM-1. Must be >= 2.
SCAN_WIDTH, 2, width of scan_idx. Must be >= clog2(SCAN_NUM).

Ports:
clksys  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
en  input  1  count enable; when low, all state is held.
div_load  input  1  one-cycle strobe that loads div_value.
div_value  input  CNT_WIDTH  new divisor D.
tick  output  1  one-cycle pulse, once per D enabled cycles.
clk_div  output  1  divided clock, period D cycles.
scan_idx  output  SCAN_WIDTH  scan position; advances on each tick.

Behaviour:
- Internal state: div_r (current D), cnt (0..D-1). All outputs are registered; no combinational input-to-output paths.
- Reset (rst high at posedge): div_r = DEFAULT_DIV, cnt = 0, tick = 0, clk_div = 0, scan_idx = 0. Reset overrides div_load and en.
- Priority each edge: rst > div_load > en.
- div_load:
  - div_r <= max(div_value, 2); values 0 and 1 clamp to 2.
  - cnt <= 0, clk_div <= 0, tick <= 0. scan_idx is held.
  - Applies regardless of en.
  - A load in the same cycle as a terminal count suppresses that tick.
- en high, no load:
  - If cnt == div_r-1: cnt <= 0, tick <= 1, scan_idx <= (scan_idx == SCAN_NUM-1) ? 0 : scan_idx+1.
  - Otherwise: cnt <= cnt+1, tick <= 0.
- en low, no load: cnt, clk_div and scan_idx hold; tick <= 0. Tick is never stretched across a pause.
- tick latency:
  - First tick is high in the cycle after the D-th enabled edge following reset or load.
  - Thereafter exactly one high cycle per D enabled cycles.
  - For D = 2, tick is high every other cycle.
- clk_div:
  - Register that always equals (cnt >= H), where H = D - (D>>1), i.e. ceil(D/2). It is computed from the next value of cnt.
  - Low for ceil(D/2) cycles, high for floor(D/2) cycles.
  - Falls in the same cycle tick rises.
- Arithmetic: all compares unsigned at CNT_WIDTH bits. cnt never exceeds div_r-1, so no counter overflow is possible. scan_idx wrap is explicit and does not rely on natural 2^SCAN_WIDTH rollover.
- Mid-period reload: takes effect immediately. The old period is abandoned and the new period starts from cnt = 0.

Optional Feature:
FREQDIV_TICK_CNT_EN
- Defined:
  - Adds output tick_cnt [15:0], the count of ticks issued since the last reset or div_load.
  - Increments on the same edge that sets tick and saturates at 16'hFFFF.
  - Reset and div_load set it to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then en = 1 with default D = 262144 -> first tick in cycle 262145; clk_div rises at cnt = 131072; scan_idx = 1 after the first tick.
- div_load with div_value = 5, en = 1 -> tick every 5 cycles; clk_div pattern 0,0,0,1,1 repeating; scan_idx sequence 0,1,2,3,0 over 20 cycles.
- div_value = 0 and div_value = 1 -> behaves as D = 2: tick every other cycle, clk_div toggles each cycle.
- D = 6, drop en for 3 cycles at cnt = 4 -> cnt, clk_div and scan_idx frozen, tick low; next tick arrives 9 cycles after the previous one.
- D = 4, assert div_load (value 8) in the terminal cycle -> no tick; next tick 8 cycles later; scan_idx unchanged by the load.
- rst asserted mid-period with D = 10 -> next edge: all outputs 0, div_r = DEFAULT_DIV. With FREQDIV_TICK_CNT_EN, tick_cnt = 0 and saturation holds at 16'hFFFF (D = 2, 65540 ticks).
